// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters with registered sync, blanking,
// line/frame strobes, band chip-select and frame counter, all advancing only on en.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int BAND_H    = 32,
    parameter int CW        = 10,
    parameter int BW        = 4,
    parameter int FW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start,
    output logic          cs,
    output logic [BW-1:0] band_idx,
    output logic [FW-1:0] frame_cnt
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int N_BANDS  = (BAND_H > 0) ? (V_DISPLAY + BAND_H - 1) / BAND_H : 1;
    localparam int XW       = CW + 1;

    // One extra bit so that window ends equal to the total still compare correctly.
    localparam logic [XW-1:0] H_LAST_X   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] V_LAST_X   = XW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_DISP_X   = XW'(H_DISPLAY);
    localparam logic [XW-1:0] V_DISP_X   = XW'(V_DISPLAY);
    localparam logic [XW-1:0] HS_START_X = XW'(HS_START);
    localparam logic [XW-1:0] HS_END_X   = XW'(HS_END);
    localparam logic [XW-1:0] VS_START_X = XW'(VS_START);
    localparam logic [XW-1:0] VS_END_X   = XW'(VS_END);
    localparam logic [CW-1:0] BAND_LAST  = CW'(BAND_H - 1);
    localparam logic          H_ACT      = (H_POL != 0);
    localparam logic          V_ACT      = (V_POL != 0);

    generate
        if (H_DISPLAY < 1 || H_SYNC < 1 || V_DISPLAY < 1 || V_SYNC < 1 ||
            H_FRONT < 0 || H_BACK < 0 || V_FRONT < 0 || V_BACK < 0) begin : g_bad_timing
            $error("vga_timing_gen: display/sync widths must be >= 1 and porches >= 0");
        end
        if (BAND_H < 1 || BAND_H > V_DISPLAY) begin : g_bad_band
            $error("vga_timing_gen: BAND_H must be within 1..V_DISPLAY");
        end
        if (CW < 1 || CW > 30 || (H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
            $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
        end
        if (BW < 1 || BW > 30 || (N_BANDS - 1) >= (1 << BW)) begin : g_bad_bw
            $error("vga_timing_gen: BW too small for the band count");
        end
        if (FW < 1) begin : g_bad_fw
            $error("vga_timing_gen: FW must be >= 1");
        end
    endgenerate

    logic          started;
    logic [CW-1:0] band_line;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          frame_wrap;
    logic [XW-1:0] h_x;
    logic [XW-1:0] v_x;

    // Position the registered outputs will describe after this en; the first en presents (0,0).
    always_comb begin
        h_nxt      = hpos;
        v_nxt      = vpos;
        frame_wrap = 1'b0;
        if (started) begin
            if ({1'b0, hpos} == H_LAST_X) begin
                h_nxt = '0;
                if ({1'b0, vpos} == V_LAST_X) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = vpos + CW'(1);
                end
            end else begin
                h_nxt = hpos + CW'(1);
            end
        end
    end

    assign h_x = {1'b0, h_nxt};
    assign v_x = {1'b0, v_nxt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started     <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= ~H_ACT;
            vsync       <= ~V_ACT;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            cs          <= 1'b0;
            band_idx    <= '0;
            band_line   <= '0;
            frame_cnt   <= '0;
        end else if (en) begin
            started     <= 1'b1;
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            hsync       <= (h_x >= HS_START_X && h_x < HS_END_X) ? H_ACT : ~H_ACT;
            vsync       <= (v_x >= VS_START_X && v_x < VS_END_X) ? V_ACT : ~V_ACT;
            display_on  <= (h_x < H_DISP_X) && (v_x < V_DISP_X);
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            // band_line tracks the line within the current band; bands only advance in the visible area.
            if (h_nxt == '0) begin
                if (v_nxt == '0) begin
                    band_line <= '0;
                    cs        <= 1'b0;
                    band_idx  <= '0;
                end else if (band_line == BAND_LAST) begin
                    band_line <= '0;
                    if (v_x < V_DISP_X) begin
                        cs       <= ~cs;
                        band_idx <= band_idx + 1'b1;
                    end
                end else begin
                    band_line <= band_line + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (24x17) so whole frames fit in a short run;
// a second instance covers active-high syncs and a single full-height band.
module tb_vga_timing_gen;

  localparam int HD = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VD = 10, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HD + HF + HSW + HB;
  localparam int VT = VD + VF + VSW + VB;
  localparam int CW = 6, BW = 2, FW = 2;
  localparam int BH_A = 3, BH_B = VD;
  localparam int W = 2 * CW + 6 + BW + FW;

  localparam logic [W-1:0] RST_A = {CW'(0), CW'(0), 1'b1, 1'b1, 4'b0000, BW'(0), FW'(0)};
  localparam logic [W-1:0] RST_B = {CW'(0), CW'(0), 1'b0, 1'b0, 4'b0000, BW'(0), FW'(0)};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  logic [CW-1:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic hsync_a, vsync_a, de_a, ls_a, fs_a, cs_a;
  logic hsync_b, vsync_b, de_b, ls_b, fs_b, cs_b;
  logic [BW-1:0] bi_a, bi_b;
  logic [FW-1:0] fc_a, fc_b;
  logic [W-1:0] vec_a, vec_b;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  int n_checks = 0;
  int n_errors = 0;

  bit m_started = 1'b0;
  int m_h = 0, m_v = 0, m_fc = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .H_POL(0), .V_POL(0), .BAND_H(BH_A), .CW(CW), .BW(BW), .FW(FW)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en),
    .hpos(hpos_a), .vpos(vpos_a), .hsync(hsync_a), .vsync(vsync_a),
    .display_on(de_a), .line_start(ls_a), .frame_start(fs_a),
    .cs(cs_a), .band_idx(bi_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .H_POL(1), .V_POL(1), .BAND_H(BH_B), .CW(CW), .BW(BW), .FW(FW)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en),
    .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
    .display_on(de_b), .line_start(ls_b), .frame_start(fs_b),
    .cs(cs_b), .band_idx(bi_b), .frame_cnt(fc_b)
  );

  assign vec_a = {hpos_a, vpos_a, hsync_a, vsync_a, de_a, ls_a, fs_a, cs_a, bi_a, fc_a};
  assign vec_b = {hpos_b, vpos_b, hsync_b, vsync_b, de_b, ls_b, fs_b, cs_b, bi_b, fc_b};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  function automatic void model_step();
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_h == HT - 1) begin
      m_h = 0;
      if (m_v == VT - 1) begin
        m_v = 0;
        m_fc++;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
  endfunction

  function automatic logic [W-1:0] model_vec(input logic h_pol, input logic v_pol, input int band_h);
    logic hs, vs, de, ls, fs, c;
    int bidx;
    if (!m_started)
      return {CW'(0), CW'(0), ~h_pol, ~v_pol, 4'b0000, BW'(0), FW'(0)};
    hs = (m_h >= HD + HF && m_h < HD + HF + HSW) ? h_pol : ~h_pol;
    vs = (m_v >= VD + VF && m_v < VD + VF + VSW) ? v_pol : ~v_pol;
    de = (m_h < HD) && (m_v < VD);
    ls = (m_h == 0);
    fs = (m_h == 0) && (m_v == 0);
    bidx = (m_v < VD) ? m_v / band_h : (VD - 1) / band_h;
    c = ((bidx % 2) == 1);
    return {CW'(m_h), CW'(m_v), hs, vs, de, ls, fs, c, BW'(bidx), FW'(m_fc)};
  endfunction

  // One clock: drive en at the falling edge, queue the model's view, compare after the rising edge.
  task automatic drive(input logic e);
    logic [W-1:0] ea, eb;
    @(negedge clk);
    en = e;
    if (e) model_step();
    exp_q_a.push_back(model_vec(1'b0, 1'b0, BH_A));
    exp_q_b.push_back(model_vec(1'b1, 1'b1, BH_B));
    @(posedge clk);
    #1;
    ea = exp_q_a.pop_front();
    eb = exp_q_b.pop_front();
    n_checks++;
    if (vec_a !== ea) begin
      n_errors++;
      $display("FAIL scoreboard_a @%0t: got %h expected %h", $time, vec_a, ea);
    end
    n_checks++;
    if (vec_b !== eb) begin
      n_errors++;
      $display("FAIL scoreboard_b @%0t: got %h expected %h", $time, vec_b, eb);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (vec_a !== RST_A) begin
      n_errors++;
      $display("FAIL reset_a: got %h expected %h", vec_a, RST_A);
    end
    n_checks++;
    if (vec_b !== RST_B) begin
      n_errors++;
      $display("FAIL reset_b: got %h expected %h", vec_b, RST_B);
    end
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    drive(1'b0);
    drive(1'b0);
    drive(1'b1);
    n_checks++;
    if (!(fs_a === 1'b1 && ls_a === 1'b1 && de_a === 1'b1 && hpos_a === '0 && vpos_a === '0)) begin
      n_errors++;
      $display("FAIL first_en: got fs=%b ls=%b de=%b h=%0d v=%0d expected fs=1 ls=1 de=1 h=0 v=0",
               fs_a, ls_a, de_a, hpos_a, vpos_a);
    end
  endtask

  task automatic test_line_timing();
    int last_ls = -1;
    int hs_cnt = 0, hs_first = -1, hs_b = 0;
    logic [CW-1:0] v_before = '0;
    for (int i = 0; i < 3 * HT; i++) begin
      drive(1'b1);
      if (i < HT) begin
        if (hsync_a == 1'b0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(hpos_a);
        end
        if (hsync_b == 1'b1) hs_b++;
      end
      if (ls_a) begin
        if (last_ls >= 0) begin
          n_checks++;
          if (i - last_ls != HT) begin
            n_errors++;
            $display("FAIL line_period: got %0d expected %0d", i - last_ls, HT);
          end
          n_checks++;
          if (vpos_a !== v_before + CW'(1)) begin
            n_errors++;
            $display("FAIL vpos_step: got %0d expected %0d", vpos_a, v_before + CW'(1));
          end
        end
        last_ls = i;
      end
      if (hpos_a == CW'(HT - 1)) v_before = vpos_a;
    end
    n_checks++;
    if (hs_cnt != HSW || hs_first != HD + HF) begin
      n_errors++;
      $display("FAIL hsync_window: got width=%0d start=%0d expected width=%0d start=%0d",
               hs_cnt, hs_first, HSW, HD + HF);
    end
    n_checks++;
    if (hs_b != HSW) begin
      n_errors++;
      $display("FAIL hsync_pol_b: got %0d high cycles expected %0d", hs_b, HSW);
    end
  endtask

  task automatic test_frame_timing();
    int seen = 0, last_fs = -1;
    for (int i = 0; i < 6 * HT * VT && seen < 5; i++) begin
      drive(1'b1);
      if (fs_a) begin
        seen++;
        if (last_fs >= 0) begin
          n_checks++;
          if (i - last_fs != HT * VT) begin
            n_errors++;
            $display("FAIL frame_period: got %0d expected %0d", i - last_fs, HT * VT);
          end
        end
        last_fs = i;
        n_checks++;
        if (fc_a !== FW'(seen) || cs_a !== 1'b0 || bi_a !== '0) begin
          n_errors++;
          $display("FAIL frame_start_state: got fc=%0d cs=%b bi=%0d expected fc=%0d cs=0 bi=0",
                   fc_a, cs_a, bi_a, FW'(seen));
        end
      end
      if (hpos_a == '0 && vpos_a == CW'(BH_A)) begin
        n_checks++;
        if (cs_a !== 1'b1 || bi_a !== BW'(1)) begin
          n_errors++;
          $display("FAIL first_band_edge: got cs=%b bi=%0d expected cs=1 bi=1", cs_a, bi_a);
        end
      end
      if (hpos_a == '0 && vpos_a == CW'(VT - 1)) begin
        n_checks++;
        if (bi_a !== BW'(3) || cs_a !== 1'b1) begin
          n_errors++;
          $display("FAIL blank_band_hold: got bi=%0d cs=%b expected bi=3 cs=1", bi_a, cs_a);
        end
        n_checks++;
        if (bi_b !== '0 || cs_b !== 1'b0) begin
          n_errors++;
          $display("FAIL single_band_b: got bi=%0d cs=%b expected bi=0 cs=0", bi_b, cs_b);
        end
      end
    end
    n_checks++;
    if (seen != 5) begin
      n_errors++;
      $display("FAIL frame_count_seen: got %0d frame starts expected 5", seen);
    end
  endtask

  task automatic test_en_gap();
    logic prev_ls;
    logic [CW-1:0] prev_h;
    int run = 0, last_rise = -1;
    logic e;
    prev_ls = ls_a;
    prev_h = hpos_a;
    for (int i = 0; i < 3 * (2 * HT + 2); i++) begin
      e = ((i % 3) == 2);
      drive(e);
      n_checks++;
      if (hpos_a !== (e ? CW'((int'(prev_h) + 1) % HT) : prev_h)) begin
        n_errors++;
        $display("FAIL gap_hpos_step: got %0d after %0d with en=%b", hpos_a, prev_h, e);
      end
      if (ls_a && !prev_ls) begin
        if (last_rise >= 0) begin
          n_checks++;
          if (i - last_rise != 3 * HT) begin
            n_errors++;
            $display("FAIL gap_line_period: got %0d expected %0d", i - last_rise, 3 * HT);
          end
        end
        last_rise = i;
        run = 1;
      end else if (ls_a && run > 0) begin
        run++;
      end else if (!ls_a && prev_ls && run > 0) begin
        n_checks++;
        if (run != 3) begin
          n_errors++;
          $display("FAIL gap_strobe_len: got %0d clocks expected 3", run);
        end
        run = 0;
      end
      prev_ls = ls_a;
      prev_h = hpos_a;
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)));
    end
    n_checks++;
    if (fc_a !== FW'(m_fc)) begin
      n_errors++;
      $display("FAIL random_frame_cnt: got %0d expected %0d", fc_a, FW'(m_fc));
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2 * HT * VT && !(m_v == 5 && m_h == 7); i++) begin
      drive(1'b1);
    end
    n_checks++;
    if (!(m_v == 5 && m_h == 7)) begin
      n_errors++;
      $display("FAIL async_target: got model at (%0d,%0d) expected (5,7)", m_v, m_h);
    end
    #2;
    reset = 1'b0;
    m_started = 1'b0;
    m_h = 0;
    m_v = 0;
    m_fc = 0;
    #1;
    n_checks++;
    if (vec_a !== RST_A) begin
      n_errors++;
      $display("FAIL async_reset_a: got %h expected %h", vec_a, RST_A);
    end
    n_checks++;
    if (vec_b !== RST_B) begin
      n_errors++;
      $display("FAIL async_reset_b: got %h expected %h", vec_b, RST_B);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (vec_a !== RST_A) begin
      n_errors++;
      $display("FAIL reset_hold_a: got %h expected %h", vec_a, RST_A);
    end
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    drive(1'b0);
    drive(1'b1);
    n_checks++;
    if (fs_a !== 1'b1 || hpos_a !== '0 || vpos_a !== '0) begin
      n_errors++;
      $display("FAIL post_reset_frame_start: got fs=%b h=%0d v=%0d expected fs=1 h=0 v=0",
               fs_a, hpos_a, vpos_a);
    end
    for (int i = 0; i < HT + 4; i++) begin
      drive(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_en_gap();
    test_random_en();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
